// File: rtl/spi_master.sv
// Mode 0 (CPOL=0, CPHA=0) SPI master: 8-bit MSB-first frames on a single chip select,
// with sclk derived from clk by a programmable half-period divider.
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       ss_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned BIT_W = 3;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD,
    GAP
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [6:0]       tx_sh;
  logic [7:0]       rx_sh;
  logic             tick_c;
  logic             accept_c;

  assign tick_c = (state != IDLE) && (div_cnt == DIV_LAST);

  // A held start is taken on the final GAP tick so back-to-back frames keep an 18*CLK_DIV cadence.
  assign accept_c = start && ((state == IDLE) || ((state == GAP) && tick_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      sclk    <= 1'b0;
      ss_n    <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) begin
        div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
      end

      if (accept_c) begin
        tx_sh   <= tx_data[6:0];
        mosi    <= tx_data[7];
        ss_n    <= 1'b0;
        busy    <= 1'b1;
        bit_cnt <= '0;
        div_cnt <= '0;
        state   <= SETUP;
      end else begin
        case (state)
          IDLE: ;

          SETUP: begin
            if (tick_c) begin
              sclk  <= 1'b1;
              rx_sh <= {rx_sh[6:0], miso};
              state <= TRANSFER;
            end
          end

          // Rising edges sample miso; falling edges present the next bit on mosi.
          TRANSFER: begin
            if (tick_c) begin
              if (!sclk) begin
                sclk  <= 1'b1;
                rx_sh <= {rx_sh[6:0], miso};
              end else begin
                sclk <= 1'b0;
                if (&bit_cnt) begin
                  state <= HOLD;
                end else begin
                  tx_sh   <= {tx_sh[5:0], 1'b0};
                  mosi    <= tx_sh[6];
                  bit_cnt <= bit_cnt + BIT_W'(1);
                end
              end
            end
          end

          HOLD: begin
            if (tick_c) begin
              ss_n    <= 1'b1;
              mosi    <= 1'b0;
              rx_data <= rx_sh;
              done    <= 1'b1;
              state   <= GAP;
            end
          end

          GAP: begin
            if (tick_c) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: four divider settings, a bench-side SPI slave model, and a
// timing model derived from the frame's edge schedule.
module tb_spi_master;

  localparam int N = 4;
  localparam int unsigned DIVS [N] = '{4, 1, 2, 255};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]      start, busy, done, sclk, ss_n, mosi, miso;
  logic [N-1:0][7:0] tx_data, rx_data;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_master #(.CLK_DIV(DIVS[g])) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start[g]),
      .tx_data (tx_data[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .rx_data (rx_data[g]),
      .sclk    (sclk[g]),
      .ss_n    (ss_n[g]),
      .mosi    (mosi[g]),
      .miso    (miso[g])
    );
  end

  typedef struct {
    int         inst;
    logic [7:0] tx;
    logic [7:0] sb;
    int         poke;
    logic [7:0] exp_rx;
    int         exp_lat;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  logic [7:0]   s_byte [N];
  logic [2:0]   s_idx  [N];
  logic [7:0]   s_rx   [N];
  logic [7:0]   exp_rx [N];
  int           r_cnt  [N];
  int           viol   [N];
  int           done_cnt  [N];
  int           last_done [N];
  logic [N-1:0] loop, prev_ss, prev_sclk;

  logic [7:0] tx_q [$];
  logic [7:0] sb_q [$];
  logic [7:0] exp_q [$];
  int         lat_q [$];

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst %0d: got %0h, expected %0h", name, i, act, exp);
    end
  endtask

  // Expected {busy, done, sclk, ss_n, mosi} t cycles after the accepting edge.
  function automatic logic [4:0] model(input int t, input int d, input logic [7:0] tx);
    int         b;
    logic [7:0] sh;
    logic       in_frame;
    if (t < 0 || t >= 18 * d) return 5'b00010;
    in_frame = (t < 17 * d);
    b = t / (2 * d);
    if (b > 7) b = 7;
    sh = tx << b;
    return {1'b1, t == 17 * d, in_frame && (t >= d) && ((t / d) % 2 == 1), !in_frame, in_frame && sh[7]};
  endfunction

  // One clock: sample outputs 1ns after the edge and advance the slave model.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    for (int i = 0; i < N; i++) begin
      if (prev_ss[i] && !ss_n[i]) begin
        s_idx[i] = 3'd7;
        r_cnt[i] = 0;
      end else if (prev_sclk[i] && !sclk[i] && s_idx[i] != 3'd0) begin
        s_idx[i] = s_idx[i] - 3'd1;
      end
      if (!prev_sclk[i] && sclk[i]) begin
        s_rx[i] = {s_rx[i][6:0], mosi[i]};
        r_cnt[i]++;
      end
      if (sclk[i] && ss_n[i]) viol[i]++;
      if (done[i]) begin
        done_cnt[i]++;
        last_done[i] = cyc_n;
      end
      miso[i]      = loop[i] ? mosi[i] : s_byte[i][s_idx[i]];
      prev_ss[i]   = ss_n[i];
      prev_sclk[i] = sclk[i];
    end
  endtask

  // Runs the frames queued in tx_q/sb_q on instance i (start held between them).
  task automatic run_seq(input int i, input int poke);
    int         d, n, t0, bad, first_bad, dc0;
    logic [4:0] e, a;
    int         dcyc [$];
    d   = int'(DIVS[i]);
    n   = tx_q.size();
    dc0 = done_cnt[i];
    t0  = 0;
    tx_data[i] = tx_q[0];
    s_byte[i]  = sb_q[0];
    start[i]   = 1'b1;
    for (int f = 0; f < n; f++) begin
      bad = 0;
      first_bad = -1;
      for (int t = 0; t < 18 * d; t++) begin
        cyc();
        if (t == 0) begin
          t0 = cyc_n;
          start[i] = (f < n - 1);
        end
        tx_data[i] = 8'($urandom);
        if (t == 18 * d - 1 && f < n - 1) begin
          tx_data[i] = tx_q[f+1];
          s_byte[i]  = sb_q[f+1];
        end
        if (f == 0 && poke > 0 && t == poke - 1) begin
          start[i]   = 1'b1;
          tx_data[i] = 8'h00;
        end else if (f == 0 && poke > 0 && t == poke) begin
          start[i] = 1'b0;
        end
        if (t >= 17 * d) exp_rx[i] = exp_q[f];
        e = model(t, d, tx_q[f]);
        a = {busy[i], done[i], sclk[i], ss_n[i], mosi[i]};
        if (a !== e || rx_data[i] !== exp_rx[i]) begin
          bad++;
          if (first_bad < 0) first_bad = t;
        end
        if (t == 17 * d) begin
          dcyc.push_back(cyc_n);
          check("rx_data", i, 32'(rx_data[i]), 32'(exp_q[f]));
          check("done_latency", i, last_done[i] - t0, lat_q[f]);
          check("slave_rx", i, 32'(s_rx[i]), 32'(tx_q[f]));
          check("rising_edges", i, r_cnt[i], 8);
        end
      end
      check($sformatf("wave f%0d first_bad_t=%0d", f, first_bad), i, bad, 0);
      if (f > 0) check("done_spacing", i, dcyc[f] - dcyc[f-1], 18 * d);
    end
    bad = 0;
    for (int t = 18 * d; t < 19 * d + 3; t++) begin
      cyc();
      e = model(t, d, 8'h00);
      a = {busy[i], done[i], sclk[i], ss_n[i], mosi[i]};
      if (a !== e || rx_data[i] !== exp_rx[i]) bad++;
    end
    check("idle_after", i, bad, 0);
    check("done_count", i, done_cnt[i] - dc0, n);
  endtask

  task automatic clear_q();
    tx_q.delete();
    sb_q.delete();
    exp_q.delete();
    lat_q.delete();
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{0, 8'hA5, 8'h3C, 0, 8'h3C, 68};
    vecs[1] = '{1, 8'h81, 8'hFF, 0, 8'hFF, 17};
    vecs[2] = '{2, 8'hF0, 8'h69, 10, 8'h69, 34};
    vecs[3] = '{3, 8'hC5, 8'h5A, 0, 8'h5A, 4335};
    vecs[4] = '{0, 8'h00, 8'hFF, 0, 8'hFF, 68};

    start = '0; tx_data = '0; miso = '0; loop = '0;
    prev_ss = '1; prev_sclk = '0;
    for (int i = 0; i < N; i++) begin
      s_byte[i] = 8'h00; s_idx[i] = 3'd0; s_rx[i] = 8'h00; exp_rx[i] = 8'h00;
      r_cnt[i] = 0; viol[i] = 0; done_cnt[i] = 0; last_done[i] = 0;
    end

    repeat (3) cyc();
    for (int i = 0; i < N; i++) begin
      check("reset_outputs", i, 32'({busy[i], done[i], sclk[i], ss_n[i], mosi[i]}), 32'(5'b00010));
      check("reset_rx_data", i, 32'(rx_data[i]), 32'h0);
    end
    rst_n = 1'b1;
    repeat (2) cyc();

    for (int v = 0; v < 5; v++) begin
      clear_q();
      tx_q.push_back(vecs[v].tx);
      sb_q.push_back(vecs[v].sb);
      exp_q.push_back(vecs[v].exp_rx);
      lat_q.push_back(vecs[v].exp_lat);
      run_seq(vecs[v].inst, vecs[v].poke);
    end

    // Held start with miso looped back to mosi: three frames back to back.
    clear_q();
    loop[0] = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      tx_q.push_back(8'(f));
      sb_q.push_back(8'h00);
      exp_q.push_back(8'(f));
      lat_q.push_back(68);
    end
    run_seq(0, 0);
    loop[0] = 1'b0;

    // Reset mid-frame after three rising edges: outputs clear without a clock edge.
    begin
      int dc;
      dc = done_cnt[0];
      s_byte[0] = 8'hC3; tx_data[0] = 8'h96; start[0] = 1'b1;
      cyc();
      start[0] = 1'b0;
      repeat (21) cyc();
      check("edges_before_reset", 0, r_cnt[0], 3);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < N; i++) exp_rx[i] = 8'h00;
      check("async_reset_outputs", 0, 32'({busy[0], done[0], sclk[0], ss_n[0], mosi[0]}), 32'(5'b00010));
      check("async_reset_rx_data", 0, 32'(rx_data[0]), 32'h0);
      repeat (2) cyc();
      rst_n = 1'b1;
      repeat (80) cyc();
      check("no_done_after_reset", 0, done_cnt[0] - dc, 0);
      check("idle_after_reset", 0, 32'({busy[0], sclk[0], ss_n[0], rx_data[0]}), 32'({3'b001, 8'h00}));
    end

    for (int k = 0; k < 24; k++) begin
      int i, d, n, poke;
      logic [7:0] tx, sb;
      i = $urandom_range(0, 2);
      d = int'(DIVS[i]);
      n = $urandom_range(1, 3);
      loop[i] = 1'($urandom_range(0, 1));
      clear_q();
      for (int f = 0; f < n; f++) begin
        tx = 8'($urandom);
        sb = 8'($urandom);
        tx_q.push_back(tx);
        sb_q.push_back(sb);
        exp_q.push_back(loop[i] ? tx : sb);
        lat_q.push_back(17 * d);
      end
      poke = (n == 1) ? $urandom_range(2, 18 * d - 2) : 0;
      run_seq(i, poke);
      loop[i] = 1'b0;
    end

    for (int i = 0; i < N; i++) check("sclk_high_while_deselected", i, viol[i], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Mode 0 SPI master (CPOL=0, CPHA=0), 8-bit frames, MSB first, single chip-select. Converts a parallel byte plus start strobe, in the system clock domain, into an SPI frame on sclk/ss_n/mosi, and returns the byte shifted in on miso. It is the initiator counterpart to the team's SPI slave; sclk is derived from the system clock by a programmable divider.

## Interface

Parameters:
- CLK_DIV, default 4: sclk half-period in clk cycles; legal range 1..255. sclk period = 2*CLK_DIV clk cycles.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a transfer; sampled only when busy=0.
- tx_data  input  8  byte to send; captured on the cycle start is accepted.
- busy  output  1  high from the cycle after acceptance until the block is ready for the next start.
- done  output  1  one-cycle pulse; rx_data valid from the same cycle.
- rx_data  output  8  last byte received on miso; held until the next done.
- sclk  output  1  SPI clock, idle low.
- ss_n  output  1  chip select, active low.
- mosi  output  1  master out.
- miso  input  1  slave out.

## Operation

- States: IDLE, SETUP, TRANSFER, HOLD, GAP. A divider counter counts 0..CLK_DIV-1 in every non-IDLE state; a "tick" is the cycle in which it reaches CLK_DIV-1, after which it restarts at 0.
- IDLE: if start=1, on that edge: tx_sh<=tx_data, ss_n<=0, mosi<=tx_data[7], busy<=1, bit_cnt<=0, divider<=0, go to SETUP. start while busy=1 is ignored; it is not queued.
- SETUP: sclk stays 0. On tick: sclk<=1 (rising edge 1), rx_sh<={rx_sh[6:0],miso}, go to TRANSFER.
- TRANSFER: on each tick, toggle sclk.
  - Rising edge (sclk 0->1): rx_sh<={rx_sh[6:0],miso}.
  - Falling edge (sclk 1->0) with bit_cnt<7: tx_sh<=tx_sh<<1, mosi<=tx_sh[6], bit_cnt<=bit_cnt+1.
  - Falling edge with bit_cnt=7: sclk<=0, go to HOLD. mosi holds bit 0.
- HOLD: sclk=0, ss_n=0. On tick: ss_n<=1, mosi<=0, rx_data<=rx_sh, done<=1, go to GAP.
- GAP: ss_n=1 for CLK_DIV cycles (minimum deselect time). On tick: busy<=0, go to IDLE.
- miso is sampled directly, with no synchronizer. It is legal because miso changes only after sclk falling edges produced by this block, at least CLK_DIV cycles before the next sample.
- Exactly 8 rising and 8 falling sclk edges occur per frame, all with ss_n=0. sclk is never high while ss_n=1.

## Timing

- Reset values (asynchronous): sclk=0, ss_n=1, mosi=0, busy=0, done=0, rx_data=8'h00, state IDLE, internal shift registers and counters 0.
- Let T0 be the clk edge that accepts start. Then:
  - ss_n falls and mosi = tx_data[7] after T0.
  - Rising edge k (k=1..8) of sclk occurs at T0 + (2k-1)*CLK_DIV; falling edge k at T0 + 2k*CLK_DIV.
  - ss_n rises and done=1 at T0 + 17*CLK_DIV; done is low on the next cycle.
  - busy falls at T0 + 18*CLK_DIV. The earliest next acceptance is that same edge if start=1.
- Total occupancy: 18*CLK_DIV cycles per byte.
- mosi setup before each sclk rising edge = CLK_DIV cycles, and it is stable for the full high phase.
- Reset asserted mid-frame: all outputs return to reset values immediately. No done pulse; the partial byte is discarded. After release, the block is in IDLE.
- start held high continuously: back-to-back frames, each separated by a CLK_DIV-cycle ss_n-high gap. tx_data is sampled at each acceptance.

## Test plan

- Reset check: assert rst_n=0 mid-frame (after 3 sclk rising edges) -> sclk=0, ss_n=1, mosi=0, busy=0, done=0, rx_data=8'h00 with no clock edge needed; no done pulse afterwards.
- Loopback with the team's spi_slave, CLK_DIV=4, master tx_data=8'hA5, slave tx_data=8'h3C -> master rx_data=8'h3C at done; slave rx_data=8'hA5 with rx_valid pulsed; done exactly 68 cycles after acceptance; busy low at 72.
- Waveform check, CLK_DIV=1, tx_data=8'h81, miso tied 1 -> exactly 8 sclk pulses each 1 cycle high/1 cycle low; mosi sequence 1,0,0,0,0,0,0,1; rx_data=8'hFF; ss_n low for 17 cycles.
- start pulsed while busy (at T0+10 with tx_data=8'h00), CLK_DIV=2, first byte 8'hF0 -> only one frame, mosi shows 8'hF0; no second frame begins.
- start held high for 3 frames, tx_data 8'h01/8'h02/8'h03, miso looped to mosi -> three done pulses 18*CLK_DIV apart; rx_data 8'h01, 8'h02, 8'h03 in order; ss_n high for exactly CLK_DIV cycles between frames.
- miso driven to 8'h5A by the model, CLK_DIV=255 -> rx_data=8'h5A; done at 17*255 cycles after acceptance; no sclk edge while ss_n=1.
